hdmi_island_scheduler: RTL

// Sequences the HDMI period type for each line from the timing generator's hCnt.

---
 rtl/hdmi_island_scheduler.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/hdmi_island_scheduler.sv
// hdmi_island_scheduler
//
// Sequences the HDMI period type for every pixel of a line from the timing
// generator's horizontal counter. It opens data islands in horizontal blanking
// and arbitrates 32-pixel packet slots among the ACR, InfoFrame and
// audio-sample packet generators. It sits between the line/frame timing
// counter and the TMDS packet/guard-band encoder, in the pixel clock domain.
//
// All outputs are registered. Each output describes the h_cnt_i value presented
// on the previous cycle.
//
// Ports
//   clk_i          pixel clock
//   rst_ni         asynchronous active-low reset
//   h_cnt_i        horizontal position, 0..WidthMax-1
//   next_active_i  next line carries active video (level, stable in blanking)
//   req_i          packet requests: [0] ACR, [1] InfoFrame, [2] audio sample
//   gnt_o          one-cycle one-hot grant, same bit order as req_i
//   pkt_sel_o      packet in current slot: 0 NULL, 1 ACR, 2 INFO, 3 AUDIO
//   pkt_idx_o      character index within the current 32-pixel slot
//   period_o       0 CTL, 1 VID_PRE, 2 VID_GB, 3 VIDEO, 4 ISL_PRE, 5 ISL_GBL,
//                  6 ISL_DATA, 7 ISL_GBT
//   isl_err_o      sticky: an island was aborted by an h_cnt_i discontinuity
//
// Build option
//   GBAHD_NULL_ISLAND_EN  when defined, an island opens on every line even with
//                         no request, and a slot with nothing pending carries a
//                         NULL packet. When undefined, NULL is never emitted.

module hdmi_island_scheduler #(
  parameter int unsigned WidthMax   = 1650,
  parameter int unsigned FrameWidth = 1280,
  parameter int unsigned CtlGap     = 4,
  parameter int unsigned MaxPkCap   = 18
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [10:0] h_cnt_i,
  input  logic        next_active_i,
  input  logic [2:0]  req_i,
  output logic [2:0]  gnt_o,
  output logic [1:0]  pkt_sel_o,
  output logic [4:0]  pkt_idx_o,
  output logic [2:0]  period_o,
  output logic        isl_err_o
);

`ifdef GBAHD_NULL_ISLAND_EN
  localparam bit NullEn = 1'b1;
`else
  localparam bit NullEn = 1'b0;
`endif

  // Slots that fit between the island overhead (8 preamble + 2 + 2 guard) and
  // the video tail (12 CTL + 8 preamble + 2 guard) of the blanking interval.
  localparam int Avail = (int'(WidthMax) - int'(FrameWidth) - int'(CtlGap) - 12 - 22) / 32;
  localparam int MaxPk = (Avail < 0) ? 0 :
                         ((Avail > int'(MaxPkCap)) ? int'(MaxPkCap) : Avail);
  localparam logic [4:0] MaxPkW    = 5'(MaxPk);
  localparam bit         IslEnable = (MaxPk >= 1);

  localparam logic [10:0] HFrame    = 11'(FrameWidth);
  localparam logic [10:0] HOpen     = 11'(FrameWidth + CtlGap - 1);
  localparam logic [10:0] HLast     = 11'(WidthMax - 1);
  localparam logic [10:0] HPreStart = 11'(WidthMax - 10);
  localparam logic [10:0] HPreEnd   = 11'(WidthMax - 3);
  localparam logic [10:0] HGbStart  = 11'(WidthMax - 2);

  localparam logic [2:0] PerCtl     = 3'd0;
  localparam logic [2:0] PerVidPre  = 3'd1;
  localparam logic [2:0] PerVidGb   = 3'd2;
  localparam logic [2:0] PerVideo   = 3'd3;
  localparam logic [2:0] PerIslPre  = 3'd4;
  localparam logic [2:0] PerIslGbl  = 3'd5;
  localparam logic [2:0] PerIslData = 3'd6;
  localparam logic [2:0] PerIslGbt  = 3'd7;

  localparam logic [1:0] SelNull  = 2'd0;
  localparam logic [1:0] SelAcr   = 2'd1;
  localparam logic [1:0] SelInfo  = 2'd2;
  localparam logic [1:0] SelAudio = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StIslPre,
    StIslGbl,
    StIslData,
    StIslGbt
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;     // preamble/guard counter, pixel index in a slot
  logic [4:0]  slot_q, slot_d;   // slots started in the current island
  logic [1:0]  sel_q, sel_d;     // packet held for the current slot
  logic        line_active_q, line_active_d;

  logic [2:0]  gnt_q, gnt_d;
  logic [1:0]  pkt_sel_q, pkt_sel_d;
  logic [4:0]  pkt_idx_q, pkt_idx_d;
  logic [2:0]  period_q, period_d;
  logic        isl_err_q, isl_err_d;

  logic [2:0]  idle_period;

  // Period outside islands: video on active lines, then the preamble and
  // leading guard band for the next line when it carries video.
  always_comb begin
    idle_period = PerCtl;
    if (h_cnt_i < HFrame) begin
      idle_period = line_active_q ? PerVideo : PerCtl;
    end else if (next_active_i && (h_cnt_i >= HPreStart) && (h_cnt_i <= HPreEnd)) begin
      idle_period = PerVidPre;
    end else if (next_active_i && (h_cnt_i >= HGbStart)) begin
      idle_period = PerVidGb;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    slot_d        = slot_q;
    sel_d         = sel_q;
    gnt_d         = 3'b000;
    pkt_sel_d     = SelNull;
    pkt_idx_d     = 5'd0;
    period_d      = PerCtl;
    isl_err_d     = isl_err_q;
    line_active_d = (h_cnt_i == HLast) ? next_active_i : line_active_q;

    unique case (state_q)
      StIdle: begin
        period_d = idle_period;
        if (IslEnable && (h_cnt_i == HOpen) && ((|req_i) || NullEn)) begin
          state_d = StIslPre;
          cnt_d   = 5'd0;
        end
      end

      StIslPre: begin
        period_d = PerIslPre;
        if (cnt_q == 5'd7) begin
          state_d = StIslGbl;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      StIslGbl: begin
        period_d = PerIslGbl;
        if (cnt_q == 5'd1) begin
          state_d = StIslData;
          cnt_d   = 5'd0;
          slot_d  = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      StIslData: begin
        period_d  = PerIslData;
        pkt_idx_d = cnt_q;
        pkt_sel_d = sel_q;
        cnt_d     = cnt_q + 5'd1;  // wraps 31 -> 0 into the next slot
        if (cnt_q == 5'd0) begin
          // Fixed priority ACR > INFO > AUDIO; losers stay pending.
          slot_d = slot_q + 5'd1;
          if (req_i[0]) begin
            sel_d = SelAcr;
            gnt_d = 3'b001;
          end else if (req_i[1]) begin
            sel_d = SelInfo;
            gnt_d = 3'b010;
          end else if (req_i[2]) begin
            sel_d = SelAudio;
            gnt_d = 3'b100;
          end else begin
            sel_d = SelNull;
          end
          pkt_sel_d = sel_d;
          if (!NullEn && !(|req_i)) begin
            // Requester withdrew before its slot: close the island rather than
            // send a NULL packet.
            state_d   = StIslGbt;
            cnt_d     = 5'd1;
            slot_d    = slot_q;
            period_d  = PerIslGbt;
            pkt_sel_d = SelNull;
            pkt_idx_d = 5'd0;
          end
        end else if (cnt_q == 5'd31) begin
          if (!((slot_q < MaxPkW) && (|req_i))) begin
            state_d = StIslGbt;
          end
        end
      end

      StIslGbt: begin
        period_d = PerIslGbt;
        if (cnt_q == 5'd1) begin
          state_d = StIdle;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = 5'd0;
      end
    endcase

    // Islands live entirely in blanking; landing in the active area (including
    // a wrap to 0) means the counter jumped, so drop the island without guard.
    if ((state_q != StIdle) && (h_cnt_i < HFrame)) begin
      state_d   = StIdle;
      cnt_d     = 5'd0;
      gnt_d     = 3'b000;
      pkt_sel_d = SelNull;
      pkt_idx_d = 5'd0;
      period_d  = PerCtl;
      isl_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      cnt_q         <= 5'd0;
      slot_q        <= 5'd0;
      sel_q         <= SelNull;
      line_active_q <= 1'b0;
      gnt_q         <= 3'b000;
      pkt_sel_q     <= SelNull;
      pkt_idx_q     <= 5'd0;
      period_q      <= PerCtl;
      isl_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      slot_q        <= slot_d;
      sel_q         <= sel_d;
      line_active_q <= line_active_d;
      gnt_q         <= gnt_d;
      pkt_sel_q     <= pkt_sel_d;
      pkt_idx_q     <= pkt_idx_d;
      period_q      <= period_d;
      isl_err_q     <= isl_err_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign pkt_sel_o = pkt_sel_q;
  assign pkt_idx_o = pkt_idx_q;
  assign period_o  = period_q;
  assign isl_err_o = isl_err_q;

endmodule
